// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and default datapath geometry.
package alu_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_OPW     = 3;
  localparam int DEF_NUM_OPS = 5;

  localparam logic [DEF_OPW-1:0] OP_AND = 3'd0;
  localparam logic [DEF_OPW-1:0] OP_OR  = 3'd1;
  localparam logic [DEF_OPW-1:0] OP_XOR = 3'd2;
  localparam logic [DEF_OPW-1:0] OP_NOR = 3'd3;
  localparam logic [DEF_OPW-1:0] OP_ADD = 3'd4;

endpackage

// File: rtl/alu_op_decoder.sv
// Opcode to one-hot slot select. Out-of-range opcodes either alias onto the
// last slot (legacy behaviour) or raise illegal with no select line active.
module alu_op_decoder
  import alu_pkg::*;
#(
  parameter int NUM_OPS    = DEF_NUM_OPS,
  parameter int OPW        = DEF_OPW,
  parameter bit ALIAS_HIGH = 1'b1
) (
  input  logic [OPW-1:0]     alu_op,
  output logic [NUM_OPS-1:0] sel,
  output logic               illegal
);

  // Exact-match decode for in-range opcodes, then the out-of-range policy.
  always_comb begin
    sel     = '0;
    illegal = 1'b0;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (alu_op == OPW'(k)) sel[k] = 1'b1;
    end
    if (32'(alu_op) >= NUM_OPS) begin
      if (ALIAS_HIGH) sel[NUM_OPS-1] = 1'b1;
      else            illegal        = 1'b1;
    end
  end

endmodule

// File: rtl/alu_result_select_pipe.sv
// Registered ALU result selector: one-hot AND-OR select of a candidate
// result, zero/negative flags, single-entry valid/ready output stage and a
// saturating counter of accepted illegal opcodes.
module alu_result_select_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int NUM_OPS    = DEF_NUM_OPS,
  parameter int OPW        = DEF_OPW,
  parameter bit ALIAS_HIGH = 1'b1,
  parameter int ERRW       = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_OPS*WIDTH-1:0] results,
  input  logic [OPW-1:0]           alu_op,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic                     out_illegal,
  output logic [ERRW-1:0]          illegal_count,
  input  logic                     clear_count
);

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
    return (&v) ? v : v + ERRW'(1);
  endfunction

  logic [NUM_OPS-1:0] sel_p0;
  logic               illegal_p0;
  logic [WIDTH-1:0]   result_p0;
  logic               zero_p0;
  logic               neg_p0;
  logic               xfer_p0;

  logic               vld_p1;
  logic [WIDTH-1:0]   result_p1;
  logic               zero_p1;
  logic               neg_p1;
  logic               illegal_p1;
  logic [ERRW-1:0]    count_p1;

  // ---- stage p0: decode, select, flags (combinational) ----
  alu_op_decoder #(
    .NUM_OPS   (NUM_OPS),
    .OPW       (OPW),
    .ALIAS_HIGH(ALIAS_HIGH)
  ) u_decoder (
    .alu_op (alu_op),
    .sel    (sel_p0),
    .illegal(illegal_p0)
  );

  // AND-OR select: at most one line is hot, so no priority is implied.
  always_comb begin
    result_p0 = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      result_p0 = result_p0 | (results[k*WIDTH +: WIDTH] & {WIDTH{sel_p0[k]}});
    end
  end

  assign zero_p0  = (result_p0 == '0);
  assign neg_p0   = result_p0[WIDTH-1];
  assign in_ready = !vld_p1 || out_ready;
  assign xfer_p0  = in_valid && in_ready;

  // ---- stage p1: output register, loaded on transfer, drained on consume ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      result_p1  <= '0;
      zero_p1    <= 1'b0;
      neg_p1     <= 1'b0;
      illegal_p1 <= 1'b0;
    end else if (xfer_p0) begin
      vld_p1     <= 1'b1;
      result_p1  <= result_p0;
      zero_p1    <= zero_p0;
      neg_p1     <= neg_p0;
      illegal_p1 <= illegal_p0;
    end else if (out_ready) begin
      vld_p1     <= 1'b0;
    end
  end

  // Illegal-opcode counter: clear has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_p1 <= '0;
    end else if (clear_count) begin
      count_p1 <= '0;
    end else if (xfer_p0 && illegal_p0) begin
      count_p1 <= sat_inc(count_p1);
    end
  end

  assign out_valid     = vld_p1;
  assign out_result    = result_p1;
  assign out_zero      = zero_p1;
  assign out_neg       = neg_p1;
  assign out_illegal   = illegal_p1;
  assign illegal_count = count_p1;

endmodule

// File: tb/tb_alu_result_select_pipe.sv
// Directed bench for alu_result_select_pipe: aliasing (A), illegal-opcode
// (B) and narrow 8-bit (C) configurations side by side.
module tb_alu_result_select_pipe;

  localparam logic [31:0] S0 = 32'h0F0F0F0F;
  localparam logic [31:0] S1 = 32'hFFFF0000;
  localparam logic [31:0] S2 = 32'h12345678;
  localparam logic [31:0] S3 = 32'h00000000;
  localparam logic [31:0] S4 = 32'h80000001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, out_ready, clr;
  logic [2:0]   op;
  logic [159:0] res;

  logic        a_in_ready, a_out_valid, a_zero, a_neg, a_ill;
  logic [31:0] a_res;
  logic [7:0]  a_cnt;
  logic        b_in_ready, b_out_valid, b_zero, b_neg, b_ill;
  logic [31:0] b_res;
  logic [7:0]  b_cnt;

  logic        c_in_valid, c_out_ready, c_clr;
  logic [1:0]  c_op;
  logic [23:0] c_in;
  logic        c_in_ready, c_out_valid, c_zero, c_neg, c_ill;
  logic [7:0]  c_res;
  logic [7:0]  c_cnt;

  int passed = 0;
  int total  = 0;

  alu_result_select_pipe #(.ALIAS_HIGH(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .results(res), .alu_op(op), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_result(a_res), .out_zero(a_zero), .out_neg(a_neg), .out_illegal(a_ill),
    .illegal_count(a_cnt), .clear_count(clr)
  );

  alu_result_select_pipe #(.ALIAS_HIGH(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .results(res), .alu_op(op), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_result(b_res), .out_zero(b_zero), .out_neg(b_neg), .out_illegal(b_ill),
    .illegal_count(b_cnt), .clear_count(clr)
  );

  alu_result_select_pipe #(.WIDTH(8), .NUM_OPS(3), .OPW(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .results(c_in), .alu_op(c_op), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_result(c_res), .out_zero(c_zero), .out_neg(c_neg), .out_illegal(c_ill),
    .illegal_count(c_cnt), .clear_count(c_clr)
  );

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr = 1'b0; op = 3'd0;
    res = {S4, S3, S2, S1, S0};
    c_in_valid = 1'b0; c_out_ready = 1'b1; c_clr = 1'b0; c_op = 2'd0; c_in = 24'h0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({a_out_valid, a_res, a_zero, a_neg, a_ill} !== 36'h0)
      $display("FAIL reset_outputs: got %h want 0", {a_out_valid, a_res, a_zero, a_neg, a_ill});
    else passed++;
    total++;
    if (a_cnt !== 8'd0 || b_cnt !== 8'd0)
      $display("FAIL reset_count: got a=%0d b=%0d want 0", a_cnt, b_cnt);
    else passed++;
    total++;
    if (a_in_ready !== 1'b1 || c_out_valid !== 1'b0)
      $display("FAIL reset_ready: got in_ready=%b c_valid=%b want 1/0", a_in_ready, c_out_valid);
    else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1)
      $display("FAIL reset_idle: got valid=%b in_ready=%b want 0/1", a_out_valid, a_in_ready);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_r [5];
    logic [4:0]  exp_z;
    logic [4:0]  exp_n;
    exp_r = '{S0, S1, S2, S3, S4};
    exp_z = 5'b01000;
    exp_n = 5'b10010;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      op = 3'(k);
      @(posedge clk); #1;
      total++;
      if ({a_out_valid, a_res, a_zero, a_neg, a_ill, a_in_ready} !==
          {1'b1, exp_r[k], exp_z[k], exp_n[k], 1'b0, 1'b1})
        $display("FAIL b2b_op%0d: got v=%b r=%h z=%b n=%b i=%b rdy=%b want v=1 r=%h z=%b n=%b i=0 rdy=1",
                 k, a_out_valid, a_res, a_zero, a_neg, a_ill, a_in_ready, exp_r[k], exp_z[k], exp_n[k]);
      else passed++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (a_out_valid !== 1'b0)
      $display("FAIL b2b_drain: got valid=%b want 0", a_out_valid);
    else passed++;
  endtask

  task automatic test_alias();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 5; k < 8; k++) begin
      op = 3'(k);
      @(posedge clk); #1;
      total++;
      if ({a_out_valid, a_res, a_ill} !== {1'b1, S4, 1'b0} || a_cnt !== 8'd0)
        $display("FAIL alias_op%0d: got v=%b r=%h i=%b cnt=%0d want v=1 r=%h i=0 cnt=0",
                 k, a_out_valid, a_res, a_ill, a_cnt, S4);
      else passed++;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    in_valid = 1'b0; out_ready = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    total++;
    if (b_cnt !== 8'd0) $display("FAIL ill_preclear: got %0d want 0", b_cnt);
    else passed++;
    in_valid = 1'b1; op = 3'd6;
    @(posedge clk); #1;
    total++;
    if ({b_out_valid, b_res, b_zero, b_neg, b_ill} !== {1'b1, 32'h0, 1'b1, 1'b0, 1'b1})
      $display("FAIL ill_op6: got v=%b r=%h z=%b n=%b i=%b want v=1 r=0 z=1 n=0 i=1",
               b_out_valid, b_res, b_zero, b_neg, b_ill);
    else passed++;
    total++;
    if (b_cnt !== 8'd1) $display("FAIL ill_count1: got %0d want 1", b_cnt);
    else passed++;
    total++;
    if (a_res !== S4 || a_ill !== 1'b0)
      $display("FAIL alias_op6_vs_b: got r=%h i=%b want r=%h i=0", a_res, a_ill, S4);
    else passed++;
    repeat (300) @(posedge clk);
    #1;
    total++;
    if (b_cnt !== 8'd255) $display("FAIL ill_saturate: got %0d want 255", b_cnt);
    else passed++;
    total++;
    if (a_cnt !== 8'd0) $display("FAIL alias_count: got %0d want 0", a_cnt);
    else passed++;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    total++;
    if (b_cnt !== 8'd0 || b_ill !== 1'b1)
      $display("FAIL ill_clear_wins: got cnt=%0d i=%b want cnt=0 i=1", b_cnt, b_ill);
    else passed++;
    op = 3'd2;
    @(posedge clk); #1;
    total++;
    if (b_cnt !== 8'd0 || b_res !== S2 || b_ill !== 1'b0)
      $display("FAIL ill_legal_after: got cnt=%0d r=%h i=%b want cnt=0 r=%h i=0", b_cnt, b_res, b_ill, S2);
    else passed++;
    op = 3'd7;
    @(posedge clk); #1;
    total++;
    if (b_cnt !== 8'd1) $display("FAIL ill_recount: got %0d want 1", b_cnt);
    else passed++;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; out_ready = 1'b1; op = 3'd2;
    @(posedge clk); #1;
    total++;
    if ({a_out_valid, a_res} !== {1'b1, S2})
      $display("FAIL bp_load: got v=%b r=%h want v=1 r=%h", a_out_valid, a_res, S2);
    else passed++;
    out_ready = 1'b0; op = 3'd0;
    #1;
    total++;
    if (a_in_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", a_in_ready);
    else passed++;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      total++;
      if ({a_out_valid, a_res, a_in_ready} !== {1'b1, S2, 1'b0})
        $display("FAIL bp_hold%0d: got v=%b r=%h rdy=%b want v=1 r=%h rdy=0",
                 k, a_out_valid, a_res, a_in_ready, S2);
      else passed++;
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (a_in_ready !== 1'b1) $display("FAIL bp_ready_pass: got %b want 1", a_in_ready);
    else passed++;
    @(posedge clk); #1;
    total++;
    if ({a_out_valid, a_res} !== {1'b1, S0})
      $display("FAIL bp_consume_load: got v=%b r=%h want v=1 r=%h", a_out_valid, a_res, S0);
    else passed++;
    in_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (a_out_valid !== 1'b0) $display("FAIL bp_drain: got %b want 0", a_out_valid);
    else passed++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; op = 3'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (a_out_valid !== 1'b1 || b_cnt !== 8'd2)
      $display("FAIL rstmid_pre: got v=%b cnt=%0d want v=1 cnt=2", a_out_valid, b_cnt);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if ({a_out_valid, a_res, a_in_ready} !== {1'b0, 32'h0, 1'b1} || b_cnt !== 8'd0)
      $display("FAIL rstmid_async: got v=%b r=%h rdy=%b cnt=%0d want v=0 r=0 rdy=1 cnt=0",
               a_out_valid, a_res, a_in_ready, b_cnt);
    else passed++;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1)
      $display("FAIL rstmid_after: got v=%b rdy=%b want 0/1", a_out_valid, a_in_ready);
    else passed++;
    out_ready = 1'b1;
  endtask

  task automatic test_narrow();
    logic [1:0] ops   [4];
    logic [7:0] exp_r [4];
    logic [3:0] exp_z;
    logic [3:0] exp_n;
    ops   = '{2'd2, 2'd3, 2'd1, 2'd0};
    exp_r = '{8'hA5, 8'hA5, 8'h00, 8'h11};
    exp_z = 4'b0100;
    exp_n = 4'b0011;
    c_in = {8'hA5, 8'h00, 8'h11};
    c_in_valid = 1'b1; c_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      c_op = ops[k];
      @(posedge clk); #1;
      total++;
      if ({c_out_valid, c_res, c_zero, c_neg, c_ill} !== {1'b1, exp_r[k], exp_z[k], exp_n[k], 1'b0})
        $display("FAIL narrow_op%0d: got v=%b r=%h z=%b n=%b i=%b want v=1 r=%h z=%b n=%b i=0",
                 ops[k], c_out_valid, c_res, c_zero, c_neg, c_ill, exp_r[k], exp_z[k], exp_n[k]);
      else passed++;
    end
    c_in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random_narrow();
    logic       m_vld;
    logic [7:0] m_res;
    logic       exp_rdy;
    int         bad_rdy;
    int         bad_out;
    m_vld = 1'b0; m_res = 8'h11; bad_rdy = 0; bad_out = 0;
    for (int i = 0; i < 2000; i++) begin
      c_in_valid  = 1'($urandom_range(0, 1));
      c_out_ready = ($urandom_range(0, 3) != 0);
      c_op        = 2'($urandom_range(0, 3));
      c_in        = 24'($urandom);
      #1;
      exp_rdy = !m_vld || c_out_ready;
      total++;
      if (c_in_ready !== exp_rdy) begin
        bad_rdy++;
        if (bad_rdy <= 5) $display("FAIL rand_ready cyc%0d: got %b want %b", i, c_in_ready, exp_rdy);
      end else passed++;
      @(posedge clk);
      if (c_in_valid && exp_rdy) begin
        m_vld = 1'b1;
        case (c_op)
          2'd0:    m_res = c_in[7:0];
          2'd1:    m_res = c_in[15:8];
          default: m_res = c_in[23:16];
        endcase
      end else if (c_out_ready) begin
        m_vld = 1'b0;
      end
      #1;
      total++;
      if (c_out_valid !== m_vld ||
          (m_vld && {c_res, c_zero, c_neg} !== {m_res, (m_res == 8'h00), m_res[7]})) begin
        bad_out++;
        if (bad_out <= 5)
          $display("FAIL rand_out cyc%0d: got v=%b r=%h z=%b n=%b want v=%b r=%h",
                   i, c_out_valid, c_res, c_zero, c_neg, m_vld, m_res);
      end else passed++;
    end
    c_in_valid = 1'b0; c_out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_alias();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_narrow();
    test_random_narrow();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
